// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks one of NUM_REQ {addr,data} offers per cycle and registers it onto the register-file write port.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module regfile_wb_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int REG_NUM_WIDTH  = 5,
   parameter int REG_DATA_WIDTH = 32
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ*REG_NUM_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic                                hold,
   output logic                                wb_en,
   output logic [REG_NUM_WIDTH-1:0]            wb_addr,
   output logic [REG_DATA_WIDTH-1:0]           wb_data,
   output logic                                conflict
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]          gnt_idx;
   logic                      gnt_any;
   logic [NUM_REQ-1:0]        grant;
   logic [REG_NUM_WIDTH-1:0]  sel_addr;
   logic [REG_DATA_WIDTH-1:0] sel_data;
   logic                      multi_valid;

`ifdef WB_ARB_RR_EN
   logic [PTR_W-1:0] rr_ptr;
   int               idx;

   // Search starts at rr_ptr and wraps; first valid index wins.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_any && req_valid[PTR_W'(idx)]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(idx);
         end
      end
      if (reset || hold) gnt_any = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset)
         rr_ptr <= '0;
      else if (gnt_any)
         rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
   end
`else
   // Descending scan so the lowest valid index is the last to overwrite.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(k);
         end
      end
      if (reset || hold) gnt_any = 1'b0;
   end
`endif

   always_comb begin
      grant    = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PTR_W'(i) == gnt_idx) begin
            sel_addr = req_addr[i*REG_NUM_WIDTH +: REG_NUM_WIDTH];
            sel_data = req_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
         end
      end
   end

   assign req_ready   = grant;
   assign multi_valid = ($countones(req_valid) > 1);

   // Register stage: x0 transfers update addr/data but never raise wb_en.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_en    <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         conflict <= 1'b0;
      end else if (gnt_any) begin
         wb_en    <= (sel_addr != '0);
         wb_addr  <= sel_addr;
         wb_data  <= sel_data;
         conflict <= multi_valid;
      end else begin
         wb_en    <= 1'b0;
         conflict <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table followed by randomized traffic checked against a rule-level model.
module tb_regfile_wb_arbiter;

   localparam int NR = 2;
   localparam int AW = 5;
   localparam int DW = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              hold;
   logic              wb_en;
   logic [AW-1:0]     wb_addr;
   logic [DW-1:0]     wb_data;
   logic              conflict;

   regfile_wb_arbiter #(.NUM_REQ(NR), .REG_NUM_WIDTH(AW), .REG_DATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .hold(hold), .wb_en(wb_en),
      .wb_addr(wb_addr), .wb_data(wb_data), .conflict(conflict)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          rst;
      logic          hld;
      logic [1:0]    valid;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic [1:0]    rdy;
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          conf;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model state
   int            m_ptr = 0;
   logic          m_en = 0, m_conf = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic [DW-1:0] rf [32];

   function automatic vec_t mk(logic rst, logic hld, logic [1:0] valid,
                               logic [AW-1:0] a0, logic [DW-1:0] d0,
                               logic [AW-1:0] a1, logic [DW-1:0] d1,
                               logic [1:0] rdy, logic en, logic [AW-1:0] addr,
                               logic [DW-1:0] data, logic conf);
      vec_t v;
      v.rst = rst; v.hld = hld; v.valid = valid; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.rdy = rdy; v.en = en; v.addr = addr; v.data = data; v.conf = conf;
      return v;
   endfunction

   function automatic int pick(logic [NR-1:0] v, int ptr);
      for (int k = 0; k < NR; k++) begin
`ifdef WB_ARB_RR_EN
         int i = (ptr + k) % NR;
`else
         int i = k;
`endif
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic do_cycle(input vec_t v, input bit use_model);
      int            g;
      logic [NR-1:0] e_rdy;
      logic [AW-1:0] sa [NR];
      logic [DW-1:0] sd [NR];
      reset = v.rst; hold = v.hld; req_valid = v.valid;
      req_addr = {v.a1, v.a0}; req_data = {v.d1, v.d0};
      sa[0] = v.a0; sa[1] = v.a1; sd[0] = v.d0; sd[1] = v.d1;
      g = pick(v.valid, m_ptr);
      e_rdy = (v.rst || v.hld || g < 0) ? '0 : NR'(1) << g;
      @(negedge clock);
      check("req_ready", 64'(req_ready), 64'(use_model ? e_rdy : v.rdy));
      @(posedge clock);
      if (v.rst) begin
         m_en = 0; m_addr = '0; m_data = '0; m_conf = 0; m_ptr = 0;
      end else if (e_rdy != '0) begin
         m_en = (sa[g] != 0); m_addr = sa[g]; m_data = sd[g];
         m_conf = ($countones(v.valid) >= 2);
         m_ptr = (g + 1) % NR;
      end else begin
         m_en = 0; m_conf = 0;
      end
      #1;
      if (wb_en === 1'b1) rf[wb_addr] = wb_data;
      check("wb_en",    64'(wb_en),    64'(use_model ? m_en   : v.en));
      check("wb_addr",  64'(wb_addr),  64'(use_model ? m_addr : v.addr));
      check("wb_data",  64'(wb_data),  64'(use_model ? m_data : v.data));
      check("conflict", 64'(conflict), 64'(use_model ? m_conf : v.conf));
   endtask

   initial begin
      vec_t v;
      reset = 1; hold = 0; req_valid = '0; req_addr = '0; req_data = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;

      // rst hld valid  a0 d0            a1  d1       rdy  en addr data          conf
      tbl.push_back(mk(1, 0, 2'b11, 3, 32'h1,        4,  32'h2,    2'b00, 0, 0, 32'h0,        0));
      tbl.push_back(mk(0, 0, 2'b01, 5, 32'hDEADBEEF, 0,  32'h0,    2'b01, 1, 5, 32'hDEADBEEF, 0));
      tbl.push_back(mk(0, 0, 2'b00, 5, 32'hDEADBEEF, 0,  32'h0,    2'b00, 0, 5, 32'hDEADBEEF, 0));
      tbl.push_back(mk(0, 0, 2'b10, 0, 32'h0,        0,  32'h1234, 2'b10, 0, 0, 32'h1234,     0));
      tbl.push_back(mk(1, 0, 2'b00, 0, 32'h0,        0,  32'h0,    2'b00, 0, 0, 32'h0,        0));
`ifdef WB_ARB_RR_EN
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 0, 2'b11, 3, 32'h30, 4, 32'h40, (i % 2) ? 2'b10 : 2'b01, 1,
                          (i % 2) ? 5'd4 : 5'd3, (i % 2) ? 32'h40 : 32'h30, 1));
`else
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 0, 2'b11, 3, 32'h30, 4, 32'h40, 2'b01, 1, 3, 32'h30, 1));
`endif
      // same index: source 0 withdraws once served, source 1 keeps offering
      tbl.push_back(mk(0, 0, 2'b11, 7, 32'hA,  7,  32'hB,  2'b01, 1, 7,  32'hA,  1));
      tbl.push_back(mk(0, 0, 2'b10, 7, 32'hA,  7,  32'hB,  2'b10, 1, 7,  32'hB,  0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 32'h0,  0,  32'h0,  2'b00, 0, 7,  32'hB,  0));
      // a write registered just before hold rises, then 3 held cycles
      tbl.push_back(mk(0, 0, 2'b01, 9, 32'h99, 10, 32'hAA, 2'b01, 1, 9,  32'h99, 0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 1, 2'b11, 9, 32'h99, 10, 32'hAA, 2'b00, 0, 9, 32'h99, 0));
`ifdef WB_ARB_RR_EN
      tbl.push_back(mk(0, 0, 2'b11, 9, 32'h99, 10, 32'hAA, 2'b10, 1, 10, 32'hAA, 1));
`else
      tbl.push_back(mk(0, 0, 2'b11, 9, 32'h99, 10, 32'hAA, 2'b01, 1, 9,  32'h99, 1));
`endif
      // reset in a granting cycle, then arbitration restarts from index 0
      tbl.push_back(mk(0, 0, 2'b01, 3, 32'h30, 4,  32'h40, 2'b01, 1, 3,  32'h30, 0));
      tbl.push_back(mk(1, 0, 2'b11, 3, 32'h30, 4,  32'h40, 2'b00, 0, 0,  32'h0,  0));
      tbl.push_back(mk(0, 0, 2'b11, 3, 32'h30, 4,  32'h40, 2'b01, 1, 3,  32'h30, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         do_cycle(tbl[i], 1'b0);
         if (i == 12) check("x7_final", 64'(rf[7]), 64'hB);
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         v.rst   = (i == 0) || ($urandom_range(0, 99) < 3);
         v.hld   = ($urandom_range(0, 99) < 10);
         v.valid = 2'($urandom);
         v.a0    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         v.a1    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         v.d0    = $urandom;
         v.d1    = $urandom;
         v.rdy = '0; v.en = 0; v.addr = '0; v.data = '0; v.conf = 0;
         do_cycle(v, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
